// File: rtl/nebula_pkg.sv
// nebula_pkg: shared widths, fetch FSM states and helpers for the instruction-block fetcher
package nebula_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam int BLOCK_WORDS = 4;
  localparam int BLOCK_ID_W = 7;
  localparam int BLOCK_W = INSTR_W * BLOCK_WORDS;
  localparam logic [BLOCK_ID_W-1:0] BLOCK_ID_RESET = BLOCK_ID_W'(1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, EMIT} fetch_state_t;
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction
endpackage

// File: rtl/instr_block_fetch_if.sv
// instr_block_fetch_if: control, memory and block-output signals of the instruction-block fetcher
interface instr_block_fetch_if;
  import nebula_pkg::*;
  logic start_in;
  logic [ADDR_W-1:0] start_pc_in;
  logic [15:0] block_count_in;
  logic flush_in;
  logic [ADDR_W-1:0] redirect_pc_in;
  logic mem_req_valid_out;
  logic mem_req_ready_in;
  logic [ADDR_W-1:0] mem_addr_out;
  logic mem_rsp_valid_in;
  logic [INSTR_W-1:0] mem_rsp_data_in;
  logic block_valid_out;
  logic block_ready_in;
  logic [BLOCK_W-1:0] block_data_out;
  logic [BLOCK_ID_W-1:0] block_id_out;
  logic busy_out;
  logic done_out;
  modport master(
    input start_in, start_pc_in, block_count_in, flush_in, redirect_pc_in,
    input mem_req_ready_in, mem_rsp_valid_in, mem_rsp_data_in, block_ready_in,
    output mem_req_valid_out, mem_addr_out, block_valid_out, block_data_out, block_id_out, busy_out, done_out
  );
  modport slave(
    output start_in, start_pc_in, block_count_in, flush_in, redirect_pc_in,
    output mem_req_ready_in, mem_rsp_valid_in, mem_rsp_data_in, block_ready_in,
    input mem_req_valid_out, mem_addr_out, block_valid_out, block_data_out, block_id_out, busy_out, done_out
  );
endinterface

// File: rtl/instr_block_fetch.sv
// instr_block_fetch: fetches 32-bit words one at a time, packs four into a tagged 128-bit block
module instr_block_fetch import nebula_pkg::*; (
  input logic clk,
  input logic rst,
  instr_block_fetch_if.master bus
);
  localparam int IDX_W = $clog2(BLOCK_WORDS);
  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0] remaining_q, remaining_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic [BLOCK_ID_W-1:0] id_q, id_d;
  logic drop_q, drop_d, done_q, done_d;
  logic req_fire, last_emit;
  assign bus.mem_req_valid_out = state_q == REQ && !drop_q;
  assign bus.mem_addr_out = pc_q;
  assign bus.block_valid_out = state_q == EMIT;
  assign bus.block_data_out = block_q;
  assign bus.block_id_out = id_q;
  assign bus.busy_out = state_q != IDLE;
  assign bus.done_out = done_q;
  assign req_fire = bus.mem_req_valid_out && bus.mem_req_ready_in;
  assign last_emit = state_q == EMIT && bus.block_ready_in && remaining_q == 16'd1;
  // next-state: fetch/pack/emit sequencing, with flush overriding everything but the final accept
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    remaining_d = remaining_q;
    word_idx_d = word_idx_q;
    block_d = block_q;
    id_d = id_q;
    done_d = 1'b0;
    drop_d = drop_q && !bus.mem_rsp_valid_in;
    case (state_q)
      IDLE: if (bus.start_in) begin
        pc_d = word_align(bus.start_pc_in);
        remaining_d = bus.block_count_in;
        word_idx_d = '0;
        done_d = bus.block_count_in == 16'd0;
        state_d = done_d ? IDLE : REQ;
      end
      REQ: if (req_fire) begin
        pc_d = pc_q + ADDR_W'(4);
        state_d = WAIT;
      end
      WAIT: if (bus.mem_rsp_valid_in) begin
        block_d[(BLOCK_WORDS - 1 - int'(word_idx_q)) * INSTR_W +: INSTR_W] = bus.mem_rsp_data_in;
        word_idx_d = word_idx_q + IDX_W'(1);
        state_d = word_idx_q == IDX_W'(BLOCK_WORDS - 1) ? EMIT : REQ;
      end
      EMIT: if (bus.block_ready_in) begin
        id_d = id_q + BLOCK_ID_W'(1);
        remaining_d = remaining_q - 16'd1;
        done_d = last_emit;
        word_idx_d = '0;
        state_d = last_emit ? IDLE : REQ;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush_in && state_q != IDLE && !last_emit) begin
      pc_d = word_align(bus.redirect_pc_in);
      word_idx_d = '0;
      state_d = REQ;
      drop_d = drop_d || req_fire || (state_q == WAIT && !bus.mem_rsp_valid_in);
    end
  end
  // state register; the block ID survives start and flush, only reset restores it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= '0;
      remaining_q <= '0;
      word_idx_q <= '0;
      block_q <= '0;
      id_q <= BLOCK_ID_RESET;
      drop_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      remaining_q <= remaining_d;
      word_idx_q <= word_idx_d;
      block_q <= block_d;
      id_q <= id_d;
      drop_q <= drop_d;
      done_q <= done_d;
    end
  end
endmodule
